// File: rtl/dram_arbiter_pkg.sv
// dram_arbiter_pkg: shared state encodings, port selects and byte-to-word shift
package dram_arbiter_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RESP   = 3'd2
  } state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int WORD_SHIFT = 2;
endpackage

// File: rtl/dram_arbiter_if.sv
// dram_arbiter_if: CPU port, debug port and RAM-side bus of the data RAM arbiter
// slave = arbiter side, master = requesters plus RAM side
interface dram_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int RAM_AW = 8
);
  logic c_req, c_we, c_ack, c_err;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic ram_en, ram_we;
  logic [RAM_AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  modport slave (
    input c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, ram_rdata,
    output c_ack, c_err, c_rdata, d_ack, d_err, d_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, ram_rdata,
    input c_ack, c_err, c_rdata, d_ack, d_err, d_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dram_rr_pick.sv
// dram_rr_pick: combinational 2-way round-robin picker
// c_req/d_req requests, ptr favoured port on conflict; valid any request, sel winner
module dram_rr_pick (
  input  logic c_req,
  input  logic d_req,
  input  logic ptr,
  output logic valid,
  output logic sel
);
  assign valid = c_req | d_req;
  assign sel = (c_req & d_req) ? ptr : d_req;
endmodule

// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the CPU and debug ports
// clk, rst (async active-low), bus (requester ports + RAM side),
// busy (not IDLE), last_grant (0 CPU, 1 debug)
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int RAM_AW = 8
) (
  input  logic clk,
  input  logic rst,
  dram_arbiter_if.slave bus,
  output logic busy,
  output logic last_grant
);
  state_t state;
  logic ptr, sel, we_q, err_q, gnt_v, gnt_sel, a_we, bad;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, c_rd_q, d_rd_q;
  dram_rr_pick u_pick (.c_req(bus.c_req), .d_req(bus.d_req), .ptr(ptr), .valid(gnt_v), .sel(gnt_sel));
  always_comb begin
    a_we = gnt_sel ? bus.d_we : bus.c_we;
    a_addr = gnt_sel ? bus.d_addr : bus.c_addr;
    a_wdata = gnt_sel ? bus.d_wdata : bus.c_wdata;
    bad = (|a_addr[WORD_SHIFT-1:0]) || (|a_addr[AW-1:RAM_AW+WORD_SHIFT]);
  end
  // RAM read data only arrives during RESP, so it is forwarded while ack is high
  assign bus.c_rdata = (bus.c_ack && !we_q && !err_q) ? bus.ram_rdata : c_rd_q;
  assign bus.d_rdata = (bus.d_ack && !we_q && !err_q) ? bus.ram_rdata : d_rd_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      ptr <= PORT_CPU;
      sel <= PORT_CPU;
      we_q <= 1'b0;
      err_q <= 1'b0;
      busy <= 1'b0;
      last_grant <= PORT_CPU;
      c_rd_q <= '0;
      d_rd_q <= '0;
      bus.c_ack <= 1'b0;
      bus.c_err <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.d_err <= 1'b0;
      bus.ram_en <= 1'b0;
      bus.ram_we <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_wdata <= '0;
    end else begin
      bus.ram_en <= 1'b0;
      bus.ram_we <= 1'b0;
      bus.c_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.c_err <= 1'b0;
      bus.d_err <= 1'b0;
      case (state)
        IDLE: if (gnt_v) begin
          sel <= gnt_sel;
          we_q <= a_we;
          err_q <= bad;
          busy <= 1'b1;
          state <= bad ? RESP : ACCESS;
          bus.ram_en <= !bad;
          bus.ram_we <= !bad && a_we;
          bus.ram_addr <= a_addr[RAM_AW+WORD_SHIFT-1:WORD_SHIFT];
          bus.ram_wdata <= a_wdata;
          bus.c_ack <= bad && gnt_sel == PORT_CPU;
          bus.c_err <= bad && gnt_sel == PORT_CPU;
          bus.d_ack <= bad && gnt_sel == PORT_DBG;
          bus.d_err <= bad && gnt_sel == PORT_DBG;
          if (bad && gnt_sel == PORT_CPU) c_rd_q <= '0;
          if (bad && gnt_sel == PORT_DBG) d_rd_q <= '0;
        end
        ACCESS: begin
          state <= RESP;
          bus.c_ack <= sel == PORT_CPU;
          bus.d_ack <= sel == PORT_DBG;
        end
        RESP: begin
          state <= IDLE;
          busy <= 1'b0;
          last_grant <= sel;
          ptr <= ~sel;
          if (!we_q && !err_q && sel == PORT_CPU) c_rd_q <= bus.ram_rdata;
          if (!we_q && !err_q && sel == PORT_DBG) d_rd_q <= bus.ram_rdata;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed self-checking bench for dram_arbiter with a behavioural RAM
module tb_dram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, last_grant;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] mem [256];
  dram_arbiter_if bus ();
  dram_arbiter dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy), .last_grant(last_grant));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else bus.ram_rdata <= mem[bus.ram_addr];
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata;
  endtask
  task automatic dbg(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
  endtask
  initial begin
    bus.ram_rdata = '0;
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0);
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_last_grant", last_grant, 0);
    chk("rst_ram_en", bus.ram_en, 0);
    chk("rst_acks", {bus.c_ack, bus.d_ack, bus.c_err, bus.d_err}, 0);
    chk("rst_c_rdata", bus.c_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    rst = 1'b1;
    tick();
    // simultaneous writes from reset: CPU first, then debug
    cpu(1, 1, 32'h0, 32'h1111_1111);
    dbg(1, 1, 32'h4, 32'h2222_2222);
    tick();
    chk("sim1_ram_en", bus.ram_en, 1);
    chk("sim1_ram_addr", bus.ram_addr, 0);
    chk("sim1_ram_wdata", bus.ram_wdata, 32'h1111_1111);
    tick();
    chk("sim1_acks", {bus.c_ack, bus.d_ack}, 2'b10);
    cpu(0, 0, 0, 0);
    tick();
    chk("sim1_last_grant", last_grant, 0);
    tick();
    chk("sim2_ram_addr", bus.ram_addr, 1);
    chk("sim2_ram_we", bus.ram_we, 1);
    tick();
    chk("sim2_acks", {bus.c_ack, bus.d_ack}, 2'b01);
    dbg(0, 0, 0, 0);
    tick();
    chk("sim2_last_grant", last_grant, 1);
    // continuous contention with reads alternates C, D, C, D
    cpu(1, 0, 32'h0, 0);
    dbg(1, 0, 32'h4, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); tick();
      chk("alt_acks", {bus.c_ack, bus.d_ack}, (i % 2 == 0) ? 2'b10 : 2'b01);
      chk("alt_rdata", (i % 2 == 0) ? bus.c_rdata : bus.d_rdata, (i % 2 == 0) ? 32'h1111_1111 : 32'h2222_2222);
      tick();
      chk("alt_last_grant", last_grant, (i % 2 == 0) ? 0 : 1);
    end
    cpu(0, 0, 0, 0);
    dbg(0, 0, 0, 0);
    // CPU write then read of 0x10
    cpu(1, 1, 32'h10, 32'hDEAD_BEEF);
    tick();
    chk("wr_ram_en_we", {bus.ram_en, bus.ram_we}, 2'b11);
    chk("wr_ram_addr", bus.ram_addr, 4);
    chk("wr_busy", busy, 1);
    chk("wr_early_ack", bus.c_ack, 0);
    tick();
    chk("wr_ack_err", {bus.c_ack, bus.c_err, bus.ram_en}, 3'b100);
    cpu(0, 0, 0, 0);
    tick();
    chk("wr_idle", {busy, bus.c_ack}, 2'b00);
    cpu(1, 0, 32'h10, 0);
    tick();
    chk("rd_ram_en_we", {bus.ram_en, bus.ram_we}, 2'b10);
    tick();
    chk("rd_ack", {bus.c_ack, bus.c_err}, 2'b10);
    chk("rd_rdata", bus.c_rdata, 32'hDEAD_BEEF);
    cpu(0, 0, 0, 0);
    tick();
    chk("rd_rdata_held", bus.c_rdata, 32'hDEAD_BEEF);
    // misaligned debug read: 1-cycle error, no RAM access, rdata cleared
    dbg(1, 0, 32'h13, 0);
    tick();
    chk("mis_ack_err", {bus.d_ack, bus.d_err, bus.c_ack}, 3'b110);
    chk("mis_ram_en", bus.ram_en, 0);
    chk("mis_rdata", bus.d_rdata, 0);
    dbg(0, 0, 0, 0);
    tick();
    chk("mis_after", {busy, bus.d_ack, bus.ram_en}, 3'b000);
    chk("mis_rdata_held", bus.d_rdata, 0);
    // last legal word, then first out-of-range word
    cpu(1, 1, 32'h3FC, 32'hCAFE_F00D);
    tick();
    chk("top_wr_ram_addr", bus.ram_addr, 8'hFF);
    chk("top_wr_ram_en", bus.ram_en, 1);
    tick();
    chk("top_wr_ack_err", {bus.c_ack, bus.c_err}, 2'b10);
    cpu(0, 0, 0, 0);
    tick();
    cpu(1, 0, 32'h3FC, 0);
    tick(); tick();
    chk("top_rd_ack_err", {bus.c_ack, bus.c_err}, 2'b10);
    chk("top_rd_rdata", bus.c_rdata, 32'hCAFE_F00D);
    cpu(0, 0, 0, 0);
    tick();
    cpu(1, 0, 32'h400, 0);
    tick();
    chk("oor_ack_err", {bus.c_ack, bus.c_err}, 2'b11);
    chk("oor_ram_en", bus.ram_en, 0);
    chk("oor_rdata", bus.c_rdata, 0);
    cpu(0, 0, 0, 0);
    tick();
    // held request: address change during ACCESS ignored, next IDLE starts a new transaction
    cpu(1, 0, 32'h10, 0);
    tick();
    chk("held1_ram_addr", bus.ram_addr, 4);
    bus.c_addr = 32'h3FC;
    tick();
    chk("held1_ack", bus.c_ack, 1);
    chk("held1_rdata", bus.c_rdata, 32'hDEAD_BEEF);
    chk("held1_ram_addr_kept", bus.ram_addr, 4);
    tick();
    chk("held_idle", {busy, bus.c_ack}, 2'b00);
    tick();
    chk("held2_ram_en_addr", {bus.ram_en, bus.ram_addr}, {1'b1, 8'hFF});
    tick();
    chk("held2_rdata", bus.c_rdata, 32'hCAFE_F00D);
    cpu(0, 0, 0, 0);
    tick();
    // reset during ACCESS of a debug read
    dbg(1, 0, 32'h4, 0);
    tick();
    chk("mid_ram_en", bus.ram_en, 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_now", {bus.ram_en, busy, bus.d_ack}, 3'b000);
    dbg(0, 0, 0, 0);
    tick();
    chk("mid_rst_noack", {bus.c_ack, bus.d_ack}, 2'b00);
    chk("mid_rst_lg_rdata", {31'b0, last_grant} | bus.d_rdata, 0);
    rst = 1'b1;
    tick();
    cpu(1, 0, 32'h0, 0);
    dbg(1, 0, 32'h4, 0);
    tick();
    chk("post_ram_addr", bus.ram_addr, 0);
    tick();
    chk("post_acks", {bus.c_ack, bus.d_ack}, 2'b10);
    chk("post_c_rdata", bus.c_rdata, 32'h1111_1111);
    cpu(0, 0, 0, 0);
    tick(); tick(); tick();
    chk("post_d_ack", {bus.c_ack, bus.d_ack}, 2'b01);
    chk("post_d_rdata", bus.d_rdata, 32'h2222_2222);
    dbg(0, 0, 0, 0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Sequences and shares the single-port data RAM between two requesters:
  - the CPU load/store path, port c_*, driven from the control FSM's mem_rd/mem_wr, ALUresult and rd2;
  - a debug/program-loader port, port d_*.
- Registered arbitration with a round-robin tie-break, one RAM access per transaction.
- Alignment and range checking; a failed check returns an error instead of accessing the RAM.
- Sits between the CPU controller/datapath and the data RAM.

Parameters:
- DW, 32, data width of both ports and the RAM.
- AW, 32, byte-address width of both requester ports.
- RAM_AW, 8, RAM word-address width (depth = 2**RAM_AW words).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- c_req  in  1  CPU request; level, held until c_ack.
- c_we  in  1  CPU write (1) / read (0).
- c_addr  in  AW  CPU byte address.
- c_wdata  in  DW  CPU write data.
- c_ack  out  1  one-cycle completion pulse.
- c_err  out  1  error flag, valid with c_ack.
- c_rdata  out  DW  read data, valid with c_ack, held until the next c_ack.
- d_req, d_we, d_addr, d_wdata, d_ack, d_err, d_rdata  same widths and meaning for the debug port.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_en with ram_we=0.
- busy  out  1  high in any state other than IDLE.
- last_grant  out  1  0 = CPU, 1 = debug; port granted most recently.

Behaviour:
- Reset:
  - state IDLE.
  - All outputs 0, including rdata registers, last_grant and the priority pointer.
  - The priority pointer points to CPU, so the CPU wins the first conflict.
- States:
  - IDLE: req is sampled only here. If any req is high, pick the winner, latch its we/addr/wdata, run the address check, and set busy.
    - Check fails: go to RESP with err pending.
    - Check passes: go to ACCESS.
  - ACCESS (exactly 1 cycle):
    - ram_en=1, ram_we = latched we, ram_addr = latched addr[RAM_AW+1:2], ram_wdata = latched wdata.
    - Go to RESP.
  - RESP (exactly 1 cycle):
    - Pulse the winner's ack.
    - Read: winner's rdata <= ram_rdata. Write: rdata unchanged.
    - err=1 only when the address check failed; in that case rdata <= 0 and the RAM is untouched.
    - Update last_grant, point the priority pointer at the loser, go to IDLE.
- Address check fails when either holds:
  - addr[1:0] != 0 (misaligned);
  - addr[AW-1:RAM_AW+2] != 0 (out of range).
- Latency from req high in IDLE to ack:
  - 2 cycles for a normal access;
  - 1 cycle for an error response.
- Arbitration:
  - Single request: granted regardless of the pointer.
  - Both requests in the same IDLE cycle: the pointer decides.
  - The loser's req stays pending and is served next, so alternation is guaranteed under continuous contention.
- Handshake:
  - A requester deasserts req at the clock edge on which it observes ack.
  - If req is still high in the following IDLE cycle, that is a new transaction.
  - req, we, addr and wdata changes after IDLE sampling have no effect on the transaction in flight.
- Other boundaries:
  - ram_en is never asserted for an erroring request.
  - Exactly one ack per transaction; c_ack and d_ack are never high together.
  - The last RAM word, addr = 4*(2**RAM_AW-1), is legal; the next word address is an error.
- Reset mid-transaction: state returns to IDLE immediately.
  - ram_en drops asynchronously.
  - No ack is issued for the aborted transaction.
  - A write in ACCESS when reset asserts may or may not have reached the RAM.
- Throughput: at most one transaction per 3 cycles (2 for errors).

Decomposition:
- Shared package holds:
  - state encodings IDLE/ACCESS/RESP (3-bit, matching the controller's state-register width);
  - the port-select constants PORT_CPU=0, PORT_DBG=1;
  - the word-offset constant 2 (byte-to-word shift).
- One natural sub-module: dram_rr_pick, a combinational 2-way round-robin picker (inputs c_req, d_req, pointer; outputs grant valid and select).
- Everything else stays in dram_arbiter.

Test Plan:
- CPU write then read:
  - c_req, we=1, addr=0x10, wdata=0xDEADBEEF -> ram_en/ram_we with ram_addr=4 one cycle after sampling; c_ack one cycle later, c_err=0.
  - Read of 0x10 -> c_rdata=0xDEADBEEF with c_ack, 2 cycles after sampling.
- Simultaneous requests from reset:
  - c_req and d_req both high -> CPU served first, then debug; last_grant goes 0 then 1.
  - Continuous contention alternates grants C, D, C, D.
- Misaligned address:
  - d_req read at addr=0x13 -> d_ack+d_err 1 cycle after sampling, ram_en never high, d_rdata=0.
- Range boundary with RAM_AW=8:
  - addr=0x3FC read -> no error, ram_addr=0xFF.
  - addr=0x400 -> error, no RAM access.
- Held req:
  - c_req kept high after c_ack -> second transaction starts in the next IDLE cycle.
  - Changing c_addr during ACCESS does not alter ram_addr.
- Reset mid-transaction:
  - rst low during ACCESS -> ram_en=0 and busy=0 immediately, no ack.
  - After rst high, a new request completes normally and the CPU has priority.
